// File: rtl/alavanca2serial.sv
// UART 8N1 transmitter for two signed 16-bit lever values: HEADER, al1 hi/lo, al2 hi/lo.
// Define ALAVANCA2SERIAL_CHECKSUM_EN to append an XOR checksum byte of the four payload bytes.
module alavanca2serial #(
   parameter int         CLKS_PER_BIT = 434,
   parameter logic [7:0] HEADER       = 8'hAA,
   parameter int         AUTO_PERIOD  = 0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] al1Bits,
   input  logic [15:0] al2Bits,
   input  logic        send,
   output logic        TX,
   output logic        busy,
   output logic        done,
   output logic [3:0]  db_estado
);

`ifdef ALAVANCA2SERIAL_CHECKSUM_EN
   localparam int N_BYTES = 6;
`else
   localparam int N_BYTES = 5;
`endif

   localparam int            TW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]    B_LAST = 3'(N_BYTES - 1);

   typedef enum logic [3:0] {
      IDLE  = 4'd0,
      START = 4'd1,
      DATA  = 4'd2,
      STOP  = 4'd3,
      NEXT  = 4'd4,
      DONE  = 4'd5
   } state_t;

   state_t        state;
   logic [TW-1:0] bit_timer;
   logic [2:0]    bit_idx;
   logic [2:0]    byte_idx;
   logic [31:0]   shadow;
   logic [7:0]    shift;
   logic [7:0]    next_byte;
   logic          tick_pend;
   logic          auto_tick;
   logic          trigger;

   generate
      if (AUTO_PERIOD > 0) begin : g_auto
         localparam int            AW     = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
         localparam logic [AW-1:0] A_LAST = AW'(AUTO_PERIOD - 1);
         logic [AW-1:0] auto_cnt;

         always_ff @(posedge clock) begin
            if (reset || auto_cnt == A_LAST) auto_cnt <= '0;
            else                             auto_cnt <= auto_cnt + 1'b1;
         end

         assign auto_tick = (auto_cnt == A_LAST);
      end else begin : g_no_auto
         assign auto_tick = 1'b0;
      end
   endgenerate

   assign trigger   = send | auto_tick | tick_pend;
   assign db_estado = state;

   // Byte that follows the one currently on the line.
   always_comb begin
      next_byte = 8'h00;
      case (byte_idx)
         3'd0: next_byte = shadow[31:24];
         3'd1: next_byte = shadow[23:16];
         3'd2: next_byte = shadow[15:8];
         3'd3: next_byte = shadow[7:0];
`ifdef ALAVANCA2SERIAL_CHECKSUM_EN
         3'd4: next_byte = shadow[31:24] ^ shadow[23:16] ^ shadow[15:8] ^ shadow[7:0];
`endif
         default: next_byte = 8'h00;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         TX        <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         bit_timer <= '0;
         bit_idx   <= 3'd0;
         byte_idx  <= 3'd0;
         shadow    <= 32'h0;
         shift     <= 8'h00;
         tick_pend <= 1'b0;
      end else begin
         if (auto_tick && state != IDLE) tick_pend <= 1'b1;

         case (state)
            IDLE: begin
               done <= 1'b0;
               if (trigger) begin
                  shadow    <= {al1Bits, al2Bits};
                  shift     <= HEADER;
                  byte_idx  <= 3'd0;
                  bit_timer <= '0;
                  busy      <= 1'b1;
                  TX        <= 1'b0;
                  tick_pend <= 1'b0;
                  state     <= START;
               end
            end
            START: begin
               if (bit_timer == T_LAST) begin
                  bit_timer <= '0;
                  bit_idx   <= 3'd0;
                  TX        <= shift[0];
                  shift     <= {1'b0, shift[7:1]};
                  state     <= DATA;
               end else begin
                  bit_timer <= bit_timer + 1'b1;
               end
            end
            DATA: begin
               if (bit_timer == T_LAST) begin
                  bit_timer <= '0;
                  if (bit_idx == 3'd7) begin
                     TX    <= 1'b1;
                     state <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     TX      <= shift[0];
                     shift   <= {1'b0, shift[7:1]};
                  end
               end else begin
                  bit_timer <= bit_timer + 1'b1;
               end
            end
            // The NEXT decision is folded into the last STOP cycle so bytes run back to back.
            STOP: begin
               if (bit_timer == T_LAST) begin
                  bit_timer <= '0;
                  if (byte_idx == B_LAST) begin
                     TX    <= 1'b1;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     byte_idx <= byte_idx + 3'd1;
                     shift    <= next_byte;
                     TX       <= 1'b0;
                     state    <= START;
                  end
               end else begin
                  bit_timer <= bit_timer + 1'b1;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alavanca2serial.sv
// Bench for alavanca2serial: decodes the TX line and compares against a packet-level model.
module tb_alavanca2serial;

   localparam int CPB = 4;
`ifdef ALAVANCA2SERIAL_CHECKSUM_EN
   localparam int NB = 6;
`else
   localparam int NB = 5;
`endif
   localparam int LEN = NB * 10 * CPB;
   localparam int ALEN = NB * 10;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        send = 1'b0;
   logic [15:0] al1Bits = 16'h0;
   logic [15:0] al2Bits = 16'h0;
   logic        TX, busy, done;
   logic [3:0]  db_estado;
   logic        p100_tx, p100_busy, p100_done;
   logic [3:0]  p100_st;
   logic        p30_tx, p30_busy, p30_done;
   logic [3:0]  p30_st;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] exp_q[$];
   logic       tx_s[$];
   logic       busy_s[$];
   logic       done_s[$];
   logic [3:0] st_s[$];

   always #5 clock = ~clock;

   alavanca2serial #(.CLKS_PER_BIT(CPB), .HEADER(8'hAA), .AUTO_PERIOD(0)) dut (
      .clock(clock), .reset(reset), .al1Bits(al1Bits), .al2Bits(al2Bits), .send(send),
      .TX(TX), .busy(busy), .done(done), .db_estado(db_estado));

   alavanca2serial #(.CLKS_PER_BIT(1), .HEADER(8'hAA), .AUTO_PERIOD(100)) dut_p100 (
      .clock(clock), .reset(reset), .al1Bits(al1Bits), .al2Bits(al2Bits), .send(1'b0),
      .TX(p100_tx), .busy(p100_busy), .done(p100_done), .db_estado(p100_st));

   alavanca2serial #(.CLKS_PER_BIT(1), .HEADER(8'hAA), .AUTO_PERIOD(30)) dut_p30 (
      .clock(clock), .reset(reset), .al1Bits(al1Bits), .al2Bits(al2Bits), .send(1'b0),
      .TX(p30_tx), .busy(p30_busy), .done(p30_done), .db_estado(p30_st));

   // Packet as it should appear on the wire, byte by byte.
   function automatic void model_packet(input logic [15:0] a1, input logic [15:0] a2);
      exp_q.push_back(8'hAA);
      exp_q.push_back(a1[15:8]);
      exp_q.push_back(a1[7:0]);
      exp_q.push_back(a2[15:8]);
      exp_q.push_back(a2[7:0]);
`ifdef ALAVANCA2SERIAL_CHECKSUM_EN
      exp_q.push_back(a1[15:8] ^ a1[7:0] ^ a2[15:8] ^ a2[7:0]);
`endif
   endfunction

   function automatic logic [7:0] rx_byte(input int b);
      logic [7:0] v;
      for (int k = 0; k < 8; k++) v[k] = tx_s[b*10*CPB + (1+k)*CPB + CPB/2];
      return v;
   endfunction

   task automatic kick(input logic [15:0] a1, input logic [15:0] a2);
      @(negedge clock);
      al1Bits = a1;
      al2Bits = a2;
      send = 1'b1;
   endtask

   task automatic capture(input int n, input int resend_at, input int chg_at);
      tx_s.delete(); busy_s.delete(); done_s.delete(); st_s.delete();
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         tx_s.push_back(TX);
         busy_s.push_back(busy);
         done_s.push_back(done);
         st_s.push_back(db_estado);
         send = (i == resend_at);
         if (i == chg_at) al1Bits = 16'h0000;
      end
      send = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      vectors++;
      if ({TX, busy, done, db_estado} !== 7'b1_0_0_0000) begin
         miscompares++;
         $display("FAIL reset_state: got %b expected 1000000", {TX, busy, done, db_estado});
      end
      vectors++;
      if ({p100_tx, p100_busy, p30_tx, p30_busy} !== 4'b1010) begin
         miscompares++;
         $display("FAIL reset_auto: got %b expected 1010", {p100_tx, p100_busy, p30_tx, p30_busy});
      end
      reset = 1'b0;
   endtask

   task automatic test_packet(input string tag, input logic [15:0] a1, input logic [15:0] a2);
      logic [7:0] got, e;
      int ferr, bl, dc, di;
      model_packet(a1, a2);
      kick(a1, a2);
      capture(LEN + 8, -1, -1);
      for (int b = 0; b < NB; b++) begin
         got = rx_byte(b);
         e = exp_q.pop_front();
         vectors++;
         if (got !== e) begin
            miscompares++;
            $display("FAIL %s byte%0d: got %h expected %h", tag, b, got, e);
         end
      end
      ferr = 0;
      for (int b = 0; b < NB; b++)
         if (tx_s[b*10*CPB + CPB/2] !== 1'b0 || tx_s[b*10*CPB + 9*CPB + CPB/2] !== 1'b1) ferr++;
      vectors++;
      if (ferr != 0) begin
         miscompares++;
         $display("FAIL %s framing: got %0d bad frames expected 0", tag, ferr);
      end
      bl = 0;
      while (bl < busy_s.size() && busy_s[bl] === 1'b1) bl++;
      vectors++;
      if (bl != LEN) begin
         miscompares++;
         $display("FAIL %s busy_len: got %0d expected %0d", tag, bl, LEN);
      end
      dc = 0; di = -1;
      foreach (done_s[i]) if (done_s[i] === 1'b1) begin dc++; di = i; end
      vectors++;
      if (dc != 1 || di != LEN) begin
         miscompares++;
         $display("FAIL %s done: got %0d pulses at %0d expected 1 at %0d", tag, dc, di, LEN);
      end
      vectors++;
      if ({st_s[0], st_s[CPB], st_s[9*CPB], st_s[LEN], st_s[LEN+1], tx_s[LEN]} !==
          {4'd1, 4'd2, 4'd3, 4'd5, 4'd0, 1'b1}) begin
         miscompares++;
         $display("FAIL %s states: got %h %h %h %h %h tx=%b expected 1 2 3 5 0 tx=1",
                  tag, st_s[0], st_s[CPB], st_s[9*CPB], st_s[LEN], st_s[LEN+1], tx_s[LEN]);
      end
   endtask

   task automatic test_busy_ignore();
      logic [7:0] got, e;
      int dc, late;
      model_packet(16'h1234, 16'hFEDC);
      kick(16'h1234, 16'hFEDC);
      capture(LEN + 8, 50, 60);
      for (int b = 0; b < NB; b++) begin
         got = rx_byte(b);
         e = exp_q.pop_front();
         vectors++;
         if (got !== e) begin
            miscompares++;
            $display("FAIL ignore byte%0d: got %h expected %h", b, got, e);
         end
      end
      dc = 0; late = 0;
      foreach (done_s[i]) if (done_s[i] === 1'b1) dc++;
      for (int i = LEN; i < busy_s.size(); i++) if (busy_s[i] !== 1'b0) late++;
      vectors++;
      if (dc != 1 || late != 0) begin
         miscompares++;
         $display("FAIL ignore_done: got %0d done, %0d busy after end expected 1, 0", dc, late);
      end
   endtask

   task automatic test_reset_mid();
      int dc, bc;
      kick(16'h1234, 16'hFEDC);
      capture(90, -1, -1);
      vectors++;
      if (st_s[89] !== 4'd2) begin
         miscompares++;
         $display("FAIL mid_state: got %h expected 2", st_s[89]);
      end
      reset = 1'b1;
      @(negedge clock);
      vectors++;
      if ({TX, busy, done, db_estado} !== 7'b1_0_0_0000) begin
         miscompares++;
         $display("FAIL mid_reset: got %b expected 1000000", {TX, busy, done, db_estado});
      end
      reset = 1'b0;
      capture(LEN + 8, -1, -1);
      dc = 0; bc = 0;
      foreach (done_s[i]) begin
         if (done_s[i] === 1'b1) dc++;
         if (busy_s[i] !== 1'b0) bc++;
      end
      vectors++;
      if (dc != 0 || bc != 0) begin
         miscompares++;
         $display("FAIL mid_abandon: got %0d done, %0d busy expected 0, 0", dc, bc);
      end
      test_packet("after_reset", 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
   endtask

   task automatic test_auto();
      int r100[$], f100[$], r30[$], f30[$];
      logic pb100, pb30;
      pb100 = p100_busy;
      pb30 = p30_busy;
      for (int i = 0; i < 420; i++) begin
         @(negedge clock);
         if (p100_busy && !pb100) r100.push_back(i);
         if (!p100_busy && pb100) f100.push_back(i);
         if (p30_busy && !pb30) r30.push_back(i);
         if (!p30_busy && pb30) f30.push_back(i);
         pb100 = p100_busy;
         pb30 = p30_busy;
      end
      vectors++;
      if (r100.size() < 4 || r30.size() < 7) begin
         miscompares++;
         $display("FAIL auto_count: got %0d and %0d starts expected >=4 and >=7", r100.size(), r30.size());
      end
      for (int k = 1; k < r100.size(); k++) begin
         vectors++;
         if (r100[k] - r100[k-1] != 100) begin
            miscompares++;
            $display("FAIL auto100_period: got %0d expected 100", r100[k] - r100[k-1]);
         end
      end
      foreach (r100[k]) foreach (f100[j]) if (f100[j] > r100[k] && (j == 0 || f100[j-1] <= r100[k])) begin
         vectors++;
         if (f100[j] - r100[k] != ALEN) begin
            miscompares++;
            $display("FAIL auto100_busy: got %0d expected %0d", f100[j] - r100[k], ALEN);
         end
      end
      foreach (f30[j]) foreach (r30[k]) if (r30[k] > f30[j] && (k == 0 || r30[k-1] <= f30[j])) begin
         vectors++;
         if (r30[k] - f30[j] != 2) begin
            miscompares++;
            $display("FAIL auto30_gap: got %0d expected 2", r30[k] - f30[j]);
         end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 4; n++)
         test_packet("random", 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
   endtask

   initial begin
      test_reset();
      test_packet("basic", 16'h1234, 16'hFEDC);
      test_busy_ignore();
      test_reset_mid();
      test_packet("sign", 16'h8000, 16'h7FFF);
      test_random();
      test_auto();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
